// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, combinational-memory capture into a DEPTH-entry buffer, redirect flush.
// Optional halt detection on the all-ones word is enabled by defining INSTR_FETCH_HALT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [31:0]     PC_INIT  = {RESET_PC[31:2], 2'b00};

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DEPTH-1:0][31:0] buf_instr_q, buf_instr_d;
  logic [DEPTH-1:0][31:0] buf_pc_q, buf_pc_d;

  logic fetch_en_s;
  logic halted_s;
  logic full_s;
  logic pop_s;
  logic capture_s;
  logic halt_word_s;

  assign Address   = pc_q;
  assign out_valid = (count_q != {CW{1'b0}});
  assign out_instr = buf_instr_q[rd_ptr_q];
  assign out_pc    = buf_pc_q[rd_ptr_q];

  assign full_s    = (count_q == FULL_CNT);
  // Redirect wins over everything: no capture and no pop in the flush cycle.
  assign pop_s     = out_valid && out_ready && !redirect;
  assign capture_s = fetch_en_s && !redirect && (!full_s || pop_s);

`ifdef INSTR_FETCH_HALT_EN
  assign halt_word_s = capture_s && (Instruction == 32'hFFFFFFFF);
  assign halted      = halted_s;
`else
  logic unused_halted_s;
  assign halt_word_s     = 1'b0;
  assign halted          = 1'b0;
  assign unused_halted_s = halted_s;
`endif

  logic [1:0] unused_target_lsb_s;
  assign unused_target_lsb_s = redirect_target[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (halt_word_s) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        if (redirect) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    fetch_en_s = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_en_s = 1'b1;
        halted_s   = 1'b0;
      end
      S_HALTED: begin
        fetch_en_s = 1'b0;
        halted_s   = 1'b1;
      end
      default: begin
        fetch_en_s = 1'b0;
        halted_s   = 1'b0;
      end
    endcase
  end

  // PC, pointers and occupancy; the buffer is a power-of-two ring so pointers wrap naturally.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = {redirect_target[31:2], 2'b00};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (capture_s) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({capture_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (capture_s) begin
      buf_instr_d[wr_ptr_q] = Instruction;
      buf_pc_d[wr_ptr_q]    = pc_q;
    end else begin
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
    end
  end

  // Clearing the payload on reset keeps out_instr/out_pc at zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= PC_INIT;
      rd_ptr_q    <= {AW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      buf_instr_q <= {DEPTH{32'h00000000}};
      buf_pc_q    <= {DEPTH{32'h00000000}};
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule
